// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter family.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_EVICT = 2'd2
  } arb_state_e;

  // Bits needed to encode 0..range-1, never less than one bit.
  function automatic int arb_width(input int range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

  // Reset value of last_owner, chosen so that requester 0 wins first.
  function automatic int rst_last_owner(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request bit scanning cyclically from
// the entry after i_last_owner.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = arb_width(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last_owner,
  output logic            o_any,
  output logic [ID_W-1:0] o_winner
);

  logic            w_found;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_sel;
  int              w_idx;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_sel    = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(i_last_owner) + k) % N;
      w_sel = ID_W'(w_idx);
      if (!w_found && i_req[w_sel]) begin
        w_found  = 1'b1;
        w_winner = w_sel;
      end
    end
  end

  assign o_any    = |i_req;
  assign o_winner = w_winner;

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter for one shared resource with a per-ownership hold limit
// and a one-cycle turnaround gap after a forced eviction.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = arb_width(N),
  parameter int CNT_W    = arb_width(MAX_HOLD + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_gnt,
  output logic            o_gnt_valid,
  output logic [ID_W-1:0] o_gnt_id,
  output logic            o_hold_expired
);

  localparam logic [ID_W-1:0]  RST_LAST_OWNER = ID_W'(rst_last_owner(N));
  localparam logic [CNT_W-1:0] HOLD_LIMIT     = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_EN        = (MAX_HOLD != 0);

  arb_state_e       r_state, w_state_nxt;
  logic [N-1:0]     r_gnt, w_gnt_nxt;
  logic             r_gnt_valid;
  logic [ID_W-1:0]  r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0]  r_last_owner, w_last_owner_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic             r_hold_expired, w_hold_expired_nxt;

  logic             w_owned, w_owner_req, w_at_limit;
  logic             w_release, w_evict, w_keep, w_take;
  logic [ID_W-1:0]  w_pick_from, w_winner;
  logic             w_any;

  assign w_owned     = (r_state == ST_OWNED);
  assign w_owner_req = i_req[r_gnt_id];
  assign w_at_limit  = HOLD_EN && (r_hold_cnt == HOLD_LIMIT);
  assign w_release   = w_owned && !w_owner_req;
  assign w_evict     = w_owned && w_owner_req && w_at_limit;
  assign w_keep      = w_owned && w_owner_req && !w_at_limit;
  assign w_take      = w_any && (!w_owned || w_release);
  // On a voluntary release the owner's bit is already clear, so scanning from it is fair.
  assign w_pick_from = w_owned ? r_gnt_id : r_last_owner;

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .i_req        (i_req),
    .i_last_owner (w_pick_from),
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_gnt          <= '0;
      r_gnt_valid    <= 1'b0;
      r_gnt_id       <= '0;
      r_last_owner   <= RST_LAST_OWNER;
      r_hold_cnt     <= '0;
      r_hold_expired <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_gnt          <= w_gnt_nxt;
      r_gnt_valid    <= |w_gnt_nxt;
      r_gnt_id       <= w_gnt_id_nxt;
      r_last_owner   <= w_last_owner_nxt;
      r_hold_cnt     <= w_hold_cnt_nxt;
      r_hold_expired <= w_hold_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_EVICT: w_state_nxt = w_any ? ST_OWNED : ST_IDLE;
      ST_OWNED: begin
        if (w_release)    w_state_nxt = w_any ? ST_OWNED : ST_IDLE;
        else if (w_evict) w_state_nxt = ST_EVICT;
      end
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt          = '0;
    w_gnt_id_nxt       = r_gnt_id;
    w_hold_cnt_nxt     = '0;
    w_last_owner_nxt   = r_last_owner;
    w_hold_expired_nxt = w_evict;
    if (w_release || w_evict) w_last_owner_nxt = r_gnt_id;
    if (w_take) begin
      w_gnt_nxt      = N'(1) << w_winner;
      w_gnt_id_nxt   = w_winner;
      w_hold_cnt_nxt = CNT_W'(1);
    end else if (w_keep) begin
      w_gnt_nxt      = r_gnt;
      w_hold_cnt_nxt = (HOLD_EN && r_hold_cnt != HOLD_LIMIT) ? r_hold_cnt + 1'b1 : r_hold_cnt;
    end
  end

  assign o_gnt          = r_gnt;
  assign o_gnt_valid    = r_gnt_valid;
  assign o_gnt_id       = r_gnt_id;
  assign o_hold_expired = r_hold_expired;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter: directed scenarios plus random
// request traffic compared against an ownership-level reference model.
module tb_rr_hold_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  = 1'b1;
  logic         rst0 = 1'b1;
  logic [N-1:0] req  = '0;
  logic [N-1:0] req0 = '0;
  logic [N-1:0] gnt, gnt0;
  logic         gnt_valid, gnt_valid0;
  logic [1:0]   gnt_id, gnt_id0;
  logic         hold_expired, hold_expired0;

  int n_checks = 0;
  int n_fail   = 0;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .o_gnt          (gnt),
    .o_gnt_valid    (gnt_valid),
    .o_gnt_id       (gnt_id),
    .o_hold_expired (hold_expired)
  );

  rr_hold_arbiter #(.N(N), .MAX_HOLD(0)) dut0 (
    .i_clk          (clk),
    .i_rst          (rst0),
    .i_req          (req0),
    .o_gnt          (gnt0),
    .o_gnt_valid    (gnt_valid0),
    .o_gnt_id       (gnt_id0),
    .o_hold_expired (hold_expired0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the resource and for how long, nothing more.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_run   = 0;
  int m_id    = 0;
  bit m_exp   = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r_rst, input logic [N-1:0] r);
    if (r_rst) begin
      m_owner = -1; m_last = N - 1; m_run = 0; m_id = 0; m_exp = 1'b0;
      return;
    end
    m_exp = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_last = m_owner;
        if (r != '0) begin
          m_owner = pick(r, m_last); m_id = m_owner; m_run = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_run == MH) begin
        m_last = m_owner; m_owner = -1; m_exp = 1'b1;
      end else begin
        m_run++;
      end
    end else if (r != '0) begin
      m_owner = pick(r, m_last); m_id = m_owner; m_run = 1;
    end
  endtask

  logic [N-1:0] prev_gnt = '0;
  int           obs_run  = 0;

  task automatic cycle(input bit r_rst, input logic [N-1:0] r);
    logic [N-1:0] e_gnt;
    rst = r_rst;
    req = r;
    @(posedge clk);
    model_step(r_rst, r);
    @(negedge clk);
    e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("gnt_id", 32'(gnt_id), 32'(m_id));
    check("hold_expired", 32'(hold_expired), 32'(m_exp));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (gnt != '0 && gnt == prev_gnt) obs_run++;
    else obs_run = (gnt != '0) ? 1 : 0;
    prev_gnt = gnt;
    check("hold_len_ok", 32'(obs_run <= MH), 32'd1);
  endtask

  initial begin
    int           pulses;
    int           order[$];
    logic [N-1:0] r;

    // Basic grant and release
    cycle(1'b1, 4'b0000);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    cycle(1'b0, 4'b0001);
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_valid", 32'(gnt_valid), 32'd1);
    cycle(1'b0, 4'b0000);
    check("t1_release", 32'(gnt), 32'd0);

    // Rotating hand-off with voluntary releases after two grant cycles
    cycle(1'b1, 4'b0000);
    for (int c = 0; c < 9; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_run == 2) r[m_owner] = 1'b0;
      cycle(1'b0, r);
      check("t2_no_bubble", 32'(gnt_valid), 32'd1);
      if (order.size() == 0 || order[$] != int'(gnt_id)) order.push_back(int'(gnt_id));
    end
    check("t2_order_len", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size() && k < 5; k++) check("t2_order", 32'(order[k]), 32'(k % N));

    // Single requester hitting the hold limit
    cycle(1'b1, 4'b0000);
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      cycle(1'b0, 4'b0010);
      if (hold_expired) pulses++;
    end
    check("t3_pulses", 32'(pulses), 32'd2);
    check("t3_regrant", 32'(gnt), 32'b0010);

    // Two requesters alternating through evictions
    cycle(1'b1, 4'b0000);
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      cycle(1'b0, 4'b0110);
      if (hold_expired) pulses++;
      if (c == 5) check("t4_second_owner", 32'(gnt), 32'b0100);
    end
    check("t4_pulses", 32'(pulses), 32'd2);
    check("t4_back_to_1", 32'(gnt), 32'b0010);

    // Owner releases in the very cycle the limit is reached
    cycle(1'b1, 4'b0000);
    for (int c = 0; c < 4; c++) cycle(1'b0, 4'b0100);
    cycle(1'b0, 4'b1000);
    check("t5_handoff", 32'(gnt), 32'b1000);
    check("t5_no_expire", 32'(hold_expired), 32'd0);

    // Reset in the middle of a grant
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0100);
    check("t6_pre", 32'(gnt), 32'b0100);
    cycle(1'b1, 4'b1111);
    check("t6_rst_drop", 32'(gnt), 32'd0);
    cycle(1'b0, 4'b1111);
    check("t6_first", 32'(gnt), 32'b0001);

    // Random sticky request traffic with occasional resets
    cycle(1'b1, 4'b0000);
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
      cycle($urandom_range(63) == 0, r);
    end

    // Unlimited hold instance
    rst0 = 1'b1;
    req0 = '0;
    @(posedge clk);
    @(negedge clk);
    check("mh0_rst", 32'(gnt0), 32'd0);
    rst0 = 1'b0;
    req0 = 4'b0010;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("mh0_gnt", 32'(gnt0), 32'b0010);
      check("mh0_expired", 32'(hold_expired0), 32'd0);
    end
    check("mh0_valid", 32'(gnt_valid0), 32'd1);
    check("mh0_id", 32'(gnt_id0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
